// File: rtl/qspi_sram_emu.sv
// qspi_sram_emu: behavioural SPI/QPI serial SRAM emulator. It is sampled entirely in the
// clk domain and backed by a 2^ADDR_WIDTH byte array.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   sck, ss_n, sio_in   master SPI clock (mode 0), chip select and data lines (async to clk)
//   sio_out, sio_oe     driven data and per-line output enables
//   qpi_mode            current QPI (all-phases-quad) mode flag
//   selected            synchronised, inverted ss_n
module qspi_sram_emu #(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned ADDR_BYTES   = 3,
    parameter int unsigned QUAD_DUMMY   = 6,
    parameter bit          QPI_AT_RESET = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck,
    input  logic       ss_n,
    input  logic [3:0] sio_in,
    output logic [3:0] sio_out,
    output logic [3:0] sio_oe,
    output logic       qpi_mode,
    output logic       selected
);
    localparam logic [7:0] AddrBits    = 8'(ADDR_BYTES * 8);
    localparam logic [7:0] DummyCycles = 8'(QUAD_DUMMY);

    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StDummy, StRead, StWrite, StIgnore
    } state_e;
    typedef enum logic [1:0] {ModeKeep, ModeEnter, ModeExit} mode_req_e;

    // Input synchronisers and edge detection
    logic       sck_meta_q, sck_sync_q, sck_prev_q;
    logic       ss_meta_q, ss_sync_q, ss_prev_q;
    logic [3:0] sio_meta_q, sio_sync_q;
    logic [1:0] init_q;
    logic       armed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_meta_q <= 1'b0;
            sck_sync_q <= 1'b0;
            sck_prev_q <= 1'b0;
            ss_meta_q  <= 1'b1;
            ss_sync_q  <= 1'b1;
            ss_prev_q  <= 1'b1;
            sio_meta_q <= 4'h0;
            sio_sync_q <= 4'h0;
            init_q     <= 2'b00;
            armed_q    <= 1'b0;
        end else begin
            sck_meta_q <= sck;
            sck_sync_q <= sck_meta_q;
            sck_prev_q <= sck_sync_q;
            ss_meta_q  <= ss_n;
            ss_sync_q  <= ss_meta_q;
            ss_prev_q  <= ss_sync_q;
            sio_meta_q <= sio_in;
            sio_sync_q <= sio_meta_q;
            init_q     <= {init_q[0], 1'b1};
            // Only arm once the synchroniser holds a real pin sample of ss_n high, so a
            // select held low across reset never starts a transaction mid-stream.
            armed_q    <= armed_q | (init_q[1] & ss_sync_q);
        end
    end

    logic active, sck_rise, sck_fall, ss_fall, ss_rise;
    assign active   = ~ss_sync_q;
    assign sck_rise = active & sck_sync_q & ~sck_prev_q;
    assign sck_fall = active & ~sck_sync_q & sck_prev_q;
    assign ss_fall  = armed_q & ss_prev_q & ~ss_sync_q;
    assign ss_rise  = ss_sync_q & ~ss_prev_q;

    // Transaction state
    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  quad_q, quad_d;
    logic                  is_rd_q, is_rd_d;
    logic                  dummy_q, dummy_d;
    logic                  qpi_q, qpi_d;
    mode_req_e             req_q, req_d;
    logic [3:0]            sio_out_q, sio_out_d;

    logic                  mem_we;
    logic [7:0]            rd_q, tx_byte;
    logic [7:0]            mem_q [2**ADDR_WIDTH];

    logic [7:0]            step, cnt_next, shift_in;
    logic [ADDR_WIDTH-1:0] addr_in, addr_inc;

    assign step     = quad_q ? 8'd4 : 8'd1;
    assign cnt_next = cnt_q + step;
    assign shift_in = quad_q ? {shift_q[3:0], sio_sync_q} : {shift_q[6:0], sio_sync_q[0]};
    // Shifting into a register only ADDR_WIDTH wide drops the unused high address bits.
    assign addr_in  = quad_q ? {addr_q[ADDR_WIDTH-5:0], sio_sync_q}
                             : {addr_q[ADDR_WIDTH-2:0], sio_sync_q[0]};
    assign addr_inc = addr_q + ADDR_WIDTH'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        quad_d    = quad_q;
        is_rd_d   = is_rd_q;
        dummy_d   = dummy_q;
        qpi_d     = qpi_q;
        req_d     = req_q;
        sio_out_d = sio_out_q;
        mem_we    = 1'b0;
        tx_byte   = shift_q;

        // Deselect wins over any sck edge seen in the same cycle.
        if (ss_rise) begin
            state_d   = StIdle;
            sio_out_d = 4'h0;
            req_d     = ModeKeep;
            if (req_q == ModeEnter) begin
                qpi_d = 1'b1;
            end else if (req_q == ModeExit) begin
                qpi_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ss_fall) begin
                        state_d = StCmd;
                        cnt_d   = 8'd0;
                        shift_d = 8'h00;
                        quad_d  = qpi_q;
                        req_d   = ModeKeep;
                    end
                end
                StCmd: begin
                    if (sck_rise) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_next;
                        if (cnt_next == 8'd8) begin
                            cnt_d   = 8'd0;
                            state_d = StAddr;
                            quad_d  = qpi_q;
                            is_rd_d = 1'b1;
                            dummy_d = 1'b0;
                            case (shift_in)
                                8'h03: ;
                                8'h02: is_rd_d = 1'b0;
                                8'hEB: begin
                                    quad_d  = 1'b1;
                                    dummy_d = (QUAD_DUMMY != 0);
                                end
                                8'h38: begin
                                    quad_d  = 1'b1;
                                    is_rd_d = 1'b0;
                                end
                                8'h35: begin
                                    state_d = StIgnore;
                                    req_d   = ModeEnter;
                                end
                                8'hF5: begin
                                    state_d = StIgnore;
                                    req_d   = ModeExit;
                                end
                                default: state_d = StIgnore;
                            endcase
                        end
                    end
                end
                StAddr: begin
                    if (sck_rise) begin
                        addr_d = addr_in;
                        cnt_d  = cnt_next;
                        if (cnt_next == AddrBits) begin
                            cnt_d   = 8'd0;
                            state_d = dummy_q ? StDummy : (is_rd_q ? StRead : StWrite);
                        end
                    end
                end
                StDummy: begin
                    if (sck_rise) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == DummyCycles) begin
                            cnt_d   = 8'd0;
                            state_d = StRead;
                        end
                    end
                end
                StRead: begin
                    if (sck_fall) begin
                        // rd_q already holds mem[addr_q] when a new byte starts.
                        if (cnt_q == 8'd0) begin
                            tx_byte = rd_q;
                            addr_d  = addr_inc;
                        end
                        sio_out_d = quad_q ? tx_byte[7:4] : {2'b00, tx_byte[7], 1'b0};
                        shift_d   = quad_q ? {tx_byte[3:0], 4'h0} : {tx_byte[6:0], 1'b0};
                        cnt_d     = (cnt_next == 8'd8) ? 8'd0 : cnt_next;
                    end
                end
                StWrite: begin
                    if (sck_rise) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_next;
                        if (cnt_next == 8'd8) begin
                            mem_we = 1'b1;
                            addr_d = addr_inc;
                            cnt_d  = 8'd0;
                        end
                    end
                end
                StIgnore: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            shift_q   <= 8'h00;
            addr_q    <= '0;
            quad_q    <= 1'b0;
            is_rd_q   <= 1'b0;
            dummy_q   <= 1'b0;
            qpi_q     <= QPI_AT_RESET;
            req_q     <= ModeKeep;
            sio_out_q <= 4'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            quad_q    <= quad_d;
            is_rd_q   <= is_rd_d;
            dummy_q   <= dummy_d;
            qpi_q     <= qpi_d;
            req_q     <= req_d;
            sio_out_q <= sio_out_d;
        end
    end

    // Byte array: not reset, synchronous read of the current address every cycle.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= shift_in;
        end
        rd_q <= mem_q[addr_q];
    end

    assign sio_out  = sio_out_q;
    assign sio_oe   = (state_q == StRead) ? (quad_q ? 4'b1111 : 4'b0010) : 4'b0000;
    assign qpi_mode = qpi_q;
    assign selected = ~ss_sync_q;

endmodule
